wb: RTL

Writeback stage of the tartaruga in-order pipeline, directly downstream of the memory stage. Each cycle it registers the memory stage's `mem_to_wb_t` output, retires the held instruction, and writes its result to the integer register file. It also supplies register reads to decode, a forwarding source to execute, the taken-branch redirect to fetch, and a retired-instruction counter.

---
 rtl/tartaruga_pkg.sv | 34 +++
 rtl/wb_regfile.sv | 60 ++++++
 rtl/wb.sv | 76 +++++++
 3 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga pipeline: register/bus widths, instruction
// descriptor and the memory-to-writeback payload.
package tartaruga_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   bus32_t;

    // Where the retiring result came from; informational for this stage.
    typedef enum logic [1:0] {
        WB_ALU      = 2'd0,
        WB_LOAD     = 2'd1,
        WB_PC_PLUS4 = 2'd2
    } wb_origin_e;

    typedef struct packed {
        bus32_t     pc;
        reg_addr_t  rd;
        logic       write_rd;
        wb_origin_e wb_origin;
        logic       store_to_mem;
    } instr_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        bus32_t result;
        logic   branch_taken;
        bus32_t branched_pc;
    } mem_to_wb_t;

endpackage

// File: rtl/wb_regfile.sv
// Integer register file: two combinational read ports with write-through
// bypass, one write port, x0 hardwired to zero, async reset clears all entries.
//   clk_i, rstn_i          clock, async active-low reset
//   we_i/waddr_i/wdata_i   write port (commits on the rising edge)
//   raddr_a_i/raddr_b_i    read addresses
//   rdata_a_o/rdata_b_o    read data (combinational)
module regfile
    import tartaruga_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  bus32_t    wdata_i,
    input  reg_addr_t raddr_a_i,
    input  reg_addr_t raddr_b_i,
    output bus32_t    rdata_a_o,
    output bus32_t    rdata_b_o
);

    bus32_t rf_q [NUM_REGS];
    bus32_t rf_d [NUM_REGS];
    logic   we_eff;

    // x0 is never written, whatever the caller asks for.
    assign we_eff = we_i && (waddr_i != '0);

    // Next-state of the array.
    always_comb begin
        rf_d = rf_q;
        if (we_eff) begin
            rf_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read ports: x0 first, then the same-cycle write, then the array.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = (we_eff && waddr_i == raddr_a_i) ? wdata_i : rf_q[raddr_a_i];
        end
        if (raddr_b_i != '0) begin
            rdata_b_o = (we_eff && waddr_i == raddr_b_i) ? wdata_i : rf_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/wb.sv
// Writeback stage: holds the memory-stage output for one cycle, retires it,
// writes the register file, and drives forwarding, redirect and instret.
//   clk_i, rstn_i                 clock, async active-low reset
//   mem_to_wb_i                   memory-stage payload
//   rs1/rs2_addr_i, _data_o       decode register reads (combinational)
//   fwd_valid_o/fwd_rd_o/fwd_data_o  forwarding source for execute
//   redirect_valid_o/redirect_pc_o   taken-branch redirect to fetch
//   instret_o                     retired-instruction counter
module wb
    import tartaruga_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  mem_to_wb_t           mem_to_wb_i,
    input  reg_addr_t            rs1_addr_i,
    input  reg_addr_t            rs2_addr_i,
    output bus32_t               rs1_data_o,
    output bus32_t               rs2_data_o,
    output logic                 fwd_valid_o,
    output reg_addr_t            fwd_rd_o,
    output bus32_t               fwd_data_o,
    output logic                 redirect_valid_o,
    output bus32_t               redirect_pc_o,
    output logic [INSTRET_W-1:0] instret_o
);

    mem_to_wb_t           wb_q, wb_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 rf_we;
    logic                 unused_fields;

    assign rf_we            = wb_q.valid && wb_q.instr.write_rd && (wb_q.instr.rd != '0);
    assign redirect_valid_o = wb_q.valid && wb_q.branch_taken;
    assign redirect_pc_o    = redirect_valid_o ? wb_q.branched_pc : '0;
    assign fwd_valid_o      = rf_we;
    assign fwd_rd_o         = wb_q.instr.rd;
    assign fwd_data_o       = wb_q.result;
    assign instret_o        = instret_q;

    assign unused_fields = ^{wb_q.instr.pc, wb_q.instr.wb_origin, wb_q.instr.store_to_mem};

    // Capture next instruction; the one arriving alongside a redirect is wrong-path.
    always_comb begin
        wb_d       = mem_to_wb_i;
        wb_d.valid = mem_to_wb_i.valid && !redirect_valid_o;
        instret_d  = instret_q + INSTRET_W'(wb_q.valid);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .we_i      (rf_we),
        .waddr_i   (wb_q.instr.rd),
        .wdata_i   (wb_q.result),
        .raddr_a_i (rs1_addr_i),
        .raddr_b_i (rs2_addr_i),
        .rdata_a_o (rs1_data_o),
        .rdata_b_o (rs2_data_o)
    );

endmodule
